// File: rtl/itch_message_dispatcher_pkg.sv
// Shared constants for the ITCH message dispatcher: type bytes, shortest legal
// message per type, start-vector bit positions and FSM states.
package itch_message_dispatcher_pkg;

   localparam int TYPE_WORD_DEF = 8;

   localparam logic [7:0] MSG_ADD = 8'h41;
   localparam logic [7:0] MSG_EXP = 8'h43;
   localparam logic [7:0] MSG_DEL = 8'h44;
   localparam logic [7:0] MSG_EXE = 8'h45;

   // Lowest word index that may carry inLast for a complete message.
   localparam logic [7:0] MIN_LAST_ADD = 8'd12;
   localparam logic [7:0] MIN_LAST_EXP = 8'd15;
   localparam logic [7:0] MIN_LAST_DEL = 8'd9;
   localparam logic [7:0] MIN_LAST_EXE = 8'd11;

   localparam int START_ADD = 0;
   localparam int START_DEL = 1;
   localparam int START_EXE = 2;
   localparam int START_EXP = 3;

   typedef logic [3:0] start_t;

   typedef enum logic [1:0] {
      ST_HDR,
      ST_BODY,
      ST_DROP
   } state_t;

endpackage

// File: rtl/itch_message_dispatcher_if.sv
// Word stream in, shared parser bus out. The producer/bench uses master,
// the dispatcher uses slave.
interface itch_message_dispatcher_if #(
   parameter int CNT_W     = 4,
   parameter int ERR_CNT_W = 16
);
   logic                 inValid;
   logic [63:0]          inData;
   logic                 inLast;
   logic                 dataValid;
   logic [63:0]          dataIn;
   logic [CNT_W-1:0]     counter;
   logic                 startAddOrder;
   logic                 startOrderDelete;
   logic                 startOrderExecuted;
   logic                 startOrderExecutedWithPrice;
   logic                 msgDone;
   logic                 msgAbort;
   logic [ERR_CNT_W-1:0] errCount;

   modport master (
      output inValid, inData, inLast,
      input  dataValid, dataIn, counter,
      input  startAddOrder, startOrderDelete, startOrderExecuted, startOrderExecutedWithPrice,
      input  msgDone, msgAbort, errCount
   );

   modport slave (
      input  inValid, inData, inLast,
      output dataValid, dataIn, counter,
      output startAddOrder, startOrderDelete, startOrderExecuted, startOrderExecutedWithPrice,
      output msgDone, msgAbort, errCount
   );
endinterface

// File: rtl/itch_message_dispatcher_type_decoder.sv
// Combinational decode of the ITCH message-type byte.
module itch_message_dispatcher_type_decoder
   import itch_message_dispatcher_pkg::*;
(
   input  logic [7:0] type_byte,
   output start_t     start_vec,
   output logic [7:0] min_last,
   output logic       known
);

   // Map the type byte onto its start line and shortest legal message.
   always_comb begin
      start_vec = '0;
      min_last  = '0;
      case (type_byte)
         MSG_ADD: begin start_vec[START_ADD] = 1'b1; min_last = MIN_LAST_ADD; end
         MSG_DEL: begin start_vec[START_DEL] = 1'b1; min_last = MIN_LAST_DEL; end
         MSG_EXE: begin start_vec[START_EXE] = 1'b1; min_last = MIN_LAST_EXE; end
         MSG_EXP: begin start_vec[START_EXP] = 1'b1; min_last = MIN_LAST_EXP; end
         default: ;
      endcase
   end

   assign known = |start_vec;

endmodule

// File: rtl/itch_message_dispatcher.sv
// ITCH dispatcher top: numbers incoming words, decodes the type word, drives
// the shared dataIn/counter bus with one start level per message type, and
// counts dropped messages.
module itch_message_dispatcher
   import itch_message_dispatcher_pkg::*;
#(
   parameter int TYPE_WORD = TYPE_WORD_DEF,
   parameter int CNT_W     = 4,
   parameter int ERR_CNT_W = 16
) (
   input logic                      clk,
   input logic                      rst,
   itch_message_dispatcher_if.slave bus
);

   // One extra index bit so the first word past the forwardable range is visible.
   localparam int               IDX_W    = CNT_W + 1;
   localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(2 ** CNT_W);
   localparam logic [IDX_W-1:0] IDX_TYPE = IDX_W'(TYPE_WORD);

   state_t               state;
   logic [IDX_W-1:0]     idx;
   logic [7:0]           idx_ext;
   start_t               lat_start;
   logic [7:0]           lat_min;
   start_t               dec_start;
   logic [7:0]           dec_min;
   logic                 dec_known;

   logic                 data_valid;
   logic [63:0]          data_in;
   logic [CNT_W-1:0]     counter;
   start_t               start;
   logic                 msg_done;
   logic                 msg_abort;
   logic [ERR_CNT_W-1:0] err_count;

   assign idx_ext = 8'(idx);

   itch_message_dispatcher_type_decoder u_decoder (
      .type_byte (bus.inData[23:16]),
      .start_vec (dec_start),
      .min_last  (dec_min),
      .known     (dec_known)
   );

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   // Message FSM with registered bus outputs; bubbles leave every strobe low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_HDR;
         idx        <= '0;
         lat_start  <= '0;
         lat_min    <= '0;
         data_valid <= 1'b0;
         data_in    <= '0;
         counter    <= '0;
         start      <= '0;
         msg_done   <= 1'b0;
         msg_abort  <= 1'b0;
         err_count  <= '0;
      end else begin
         data_valid <= 1'b0;
         counter    <= '0;
         start      <= '0;
         msg_done   <= 1'b0;
         msg_abort  <= 1'b0;
         if (bus.inValid) begin
            data_in <= bus.inData;
            // Index parks at IDX_MAX while an oversize message is swallowed.
            if (bus.inLast)          idx <= '0;
            else if (idx != IDX_MAX) idx <= idx + 1'b1;
            case (state)
               ST_HDR: begin
                  if (idx < IDX_TYPE) begin
                     data_valid <= 1'b1;
                     counter    <= idx[CNT_W-1:0];
                     if (bus.inLast) err_count <= sat_inc(err_count);
                  end else if (dec_known) begin
                     data_valid <= 1'b1;
                     counter    <= idx[CNT_W-1:0];
                     lat_start  <= dec_start;
                     lat_min    <= dec_min;
                     if (bus.inLast && idx_ext < dec_min) begin
                        msg_abort <= 1'b1;
                        err_count <= sat_inc(err_count);
                     end else begin
                        start <= dec_start;
                        if (bus.inLast) msg_done <= 1'b1;
                        else            state    <= ST_BODY;
                     end
                  end else begin
                     err_count <= sat_inc(err_count);
                     if (!bus.inLast) state <= ST_DROP;
                  end
               end
               ST_BODY: begin
                  if (idx == IDX_MAX) begin
                     msg_abort <= 1'b1;
                     err_count <= sat_inc(err_count);
                     state     <= bus.inLast ? ST_HDR : ST_DROP;
                  end else begin
                     data_valid <= 1'b1;
                     counter    <= idx[CNT_W-1:0];
                     if (bus.inLast) begin
                        state <= ST_HDR;
                        if (idx_ext < lat_min) begin
                           msg_abort <= 1'b1;
                           err_count <= sat_inc(err_count);
                        end else begin
                           start    <= lat_start;
                           msg_done <= 1'b1;
                        end
                     end else begin
                        start <= lat_start;
                     end
                  end
               end
               ST_DROP: begin
                  if (bus.inLast) state <= ST_HDR;
               end
               default: state <= ST_HDR;
            endcase
         end
      end
   end

   assign bus.dataValid                   = data_valid;
   assign bus.dataIn                      = data_in;
   assign bus.counter                     = counter;
   assign bus.startAddOrder               = start[START_ADD];
   assign bus.startOrderDelete            = start[START_DEL];
   assign bus.startOrderExecuted          = start[START_EXE];
   assign bus.startOrderExecutedWithPrice = start[START_EXP];
   assign bus.msgDone                     = msg_done;
   assign bus.msgAbort                    = msg_abort;
   assign bus.errCount                    = err_count;

endmodule

// File: tb/tb_itch_message_dispatcher.sv
// Self-checking bench for itch_message_dispatcher. Each packet is described by
// its length and type byte; a packet-level reference model predicts every
// output word.
module tb_itch_message_dispatcher;

   localparam int TW = 8;

   typedef struct packed {
      logic        dv;
      logic [3:0]  cnt;
      logic [3:0]  st;     // {exec-with-price, executed, delete, add}
      logic        done;
      logic        abort;
      logic [15:0] err;
      logic [63:0] data;
   } obs_t;

   typedef struct {
      int         len;
      logic [7:0] t;
      int         fwd;
      int         starts;
      int         done;
      int         abort;
      int         err;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   itch_message_dispatcher_if #(.CNT_W(4), .ERR_CNT_W(16)) bus();

   itch_message_dispatcher #(.TYPE_WORD(TW), .CNT_W(4), .ERR_CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] model_err = '0;
   int          s_fwd, s_start, s_done, s_abort;

   task automatic bump_err();
      if (model_err != 16'hFFFF) model_err = model_err + 16'd1;
   endtask

   task automatic type_info(input logic [7:0] t, output logic known, output int mn, output logic [3:0] st);
      known = 1'b1;
      case (t)
         8'h41:   begin mn = 12; st = 4'b0001; end
         8'h44:   begin mn = 9;  st = 4'b0010; end
         8'h45:   begin mn = 11; st = 4'b0100; end
         8'h43:   begin mn = 15; st = 4'b1000; end
         default: begin mn = 0;  st = 4'b0000; known = 1'b0; end
      endcase
   endtask

   // Expected output for word i of a packet of len words whose type word carries t.
   task automatic model_word(input int i, input int len, input logic [7:0] t, input logic [63:0] w, output obs_t e);
      logic       known;
      int         mn;
      logic [3:0] st;
      type_info(t, known, mn, st);
      e = '0;
      if (len - 1 < TW || i < TW) begin
         e.dv = 1'b1;
         if (i == len - 1) bump_err();
      end else if (!known) begin
         if (i == TW) bump_err();
      end else if (i > 15) begin
         if (i == 16) begin
            e.abort = 1'b1;
            bump_err();
         end
      end else if (i == len - 1 && i < mn) begin
         e.dv    = 1'b1;
         e.abort = 1'b1;
         bump_err();
      end else begin
         e.dv   = 1'b1;
         e.st   = st;
         e.done = (i == len - 1);
      end
      if (e.dv) begin
         e.cnt  = 4'(i);
         e.data = w;
      end
      e.err = model_err;
   endtask

   task automatic compare(input string name, input int i, input obs_t e);
      obs_t a;
      a.dv    = bus.dataValid;
      a.cnt   = bus.counter;
      a.st    = {bus.startOrderExecutedWithPrice, bus.startOrderExecuted,
                 bus.startOrderDelete, bus.startAddOrder};
      a.done  = bus.msgDone;
      a.abort = bus.msgAbort;
      a.err   = bus.errCount;
      a.data  = bus.dataValid ? bus.dataIn : 64'h0;
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s[%0d]: got dv=%0b cnt=%0d st=%b done=%0b abort=%0b err=%0d data=%h, want dv=%0b cnt=%0d st=%b done=%0b abort=%0b err=%0d data=%h",
                  name, i, a.dv, a.cnt, a.st, a.done, a.abort, a.err, a.data,
                  e.dv, e.cnt, e.st, e.done, e.abort, e.err, e.data);
      end
      s_fwd   += int'(a.dv);
      s_start += int'(a.st != 4'b0);
      s_done  += int'(a.done);
      s_abort += int'(a.abort);
   endtask

   task automatic drive_check(input string name, input int i, input logic v, input logic [63:0] d,
                              input logic l, input obs_t e);
      bus.inValid = v;
      bus.inData  = d;
      bus.inLast  = l;
      @(posedge clk);
      #1;
      compare(name, i, e);
   endtask

   // Sends words 0..stop_at-1 of a len-word packet; a bubble follows word
   // bubble_after and, with probability bubble_pct, any other word.
   task automatic send_packet(input int len, input logic [7:0] t, input int bubble_after,
                              input int bubble_pct, input int stop_at);
      obs_t        e;
      logic [63:0] w;
      s_fwd = 0; s_start = 0; s_done = 0; s_abort = 0;
      for (int i = 0; i < stop_at; i++) begin
         w = {$urandom, $urandom};
         if (i == TW) w[23:16] = t;
         model_word(i, len, t, w, e);
         drive_check("word", i, 1'b1, w, (i == len - 1), e);
         if (i == bubble_after || int'($urandom_range(99)) < bubble_pct) begin
            e = '0;
            e.err = model_err;
            drive_check("bubble", i, 1'b0, {$urandom, $urandom}, 1'($urandom_range(1)), e);
         end
      end
   endtask

   vec_t        vecs[12];
   int          exp_err_tbl;
   obs_t        e0;
   logic [7:0]  rt;

   initial begin
      vecs[0]  = '{16, 8'h43, 16, 8, 1, 0, 0};   // full exec-with-price
      vecs[1]  = '{12, 8'h5A,  8, 0, 0, 0, 1};   // unknown type
      vecs[2]  = '{10, 8'h45, 10, 1, 0, 1, 1};   // executed truncated at 9
      vecs[3]  = '{20, 8'h43, 16, 8, 0, 1, 1};   // oversize
      vecs[4]  = '{13, 8'h41, 13, 5, 1, 0, 0};   // add, last exactly at minimum
      vecs[5]  = '{12, 8'h41, 12, 3, 0, 1, 1};   // add, one word short
      vecs[6]  = '{10, 8'h44, 10, 2, 1, 0, 0};   // delete at minimum
      vecs[7]  = '{ 5, 8'h00,  5, 0, 0, 0, 1};   // runt
      vecs[8]  = '{12, 8'h45, 12, 4, 1, 0, 0};   // executed at minimum
      vecs[9]  = '{ 9, 8'h44,  9, 0, 0, 1, 1};   // last on the type word
      vecs[10] = '{ 1, 8'h00,  1, 0, 0, 0, 1};   // single-word runt
      vecs[11] = '{17, 8'h45, 16, 8, 0, 1, 1};   // last is the first unforwardable word

      bus.inValid = 1'b0;
      bus.inData  = '0;
      bus.inLast  = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      e0 = '0;
      compare("reset_state", 0, e0);
      #2 rst = 1'b1;

      exp_err_tbl = 0;
      for (int k = 0; k < 12; k++) begin
         send_packet(vecs[k].len, vecs[k].t, -1, 0, vecs[k].len);
         exp_err_tbl += vecs[k].err;
         n_checks++;
         if (s_fwd != vecs[k].fwd || s_start != vecs[k].starts || s_done != vecs[k].done ||
             s_abort != vecs[k].abort || bus.errCount !== 16'(exp_err_tbl)) begin
            n_fail++;
            $display("FAIL vec%0d: got fwd=%0d starts=%0d done=%0d abort=%0d err=%0d, want fwd=%0d starts=%0d done=%0d abort=%0d err=%0d",
                     k, s_fwd, s_start, s_done, s_abort, bus.errCount,
                     vecs[k].fwd, vecs[k].starts, vecs[k].done, vecs[k].abort, exp_err_tbl);
         end
      end

      // Exec-with-price with a bubble between words 10 and 11.
      send_packet(16, 8'h43, 10, 0, 16);

      // Reset in the middle of a message, right after counter 12 is on the bus.
      send_packet(16, 8'h43, -1, 0, 13);
      bus.inValid = 1'b0;
      bus.inLast  = 1'b0;
      #2 rst = 1'b0;
      #1;
      model_err = '0;
      e0 = '0;
      compare("async_reset", 0, e0);
      @(negedge clk);
      rst = 1'b1;
      send_packet(13, 8'h41, -1, 0, 13);

      // Random packets with random bubbles.
      for (int p = 0; p < 60; p++) begin
         case ($urandom_range(4))
            0:       rt = 8'h41;
            1:       rt = 8'h44;
            2:       rt = 8'h45;
            3:       rt = 8'h43;
            default: rt = 8'($urandom_range(255, 70));
         endcase
         begin
            int len;
            len = int'($urandom_range(24, 1));
            send_packet(len, rt, -1, 20, len);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
